// File: rtl/spi_mem_ctrl_n.sv
// SPI memory controller: issues 0x02 (write) / 0x03 (read) transactions to
// one of NUM_CS SPI devices in mode 0, two clk cycles per SPI bit.
module spi_mem_ctrl_n #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = 2,
  parameter int NUM_CS    = 2,
  parameter int DESEL_CYC = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   req_valid_in,
  output logic                   req_ready_out,
  input  logic                   req_wr_in,
  input  logic [1:0]             req_cs_sel_in,
  input  logic [ADDR_W-1:0]      req_addr_in,
  input  logic [1:0]             req_len_in,
  input  logic [8*MAX_BYTES-1:0] req_wdata_in,
  output logic [8*MAX_BYTES-1:0] rdata_out,
  output logic                   rdata_valid_out,
  output logic                   done_out,
  output logic                   err_out,
  output logic                   sclk_out,
  output logic                   mosi_out,
  input  logic                   miso_in,
  output logic [NUM_CS-1:0]      cs_n_out
);

  localparam int DATA_W = 8 * MAX_BYTES;
  // Command, address and data are shifted out of one register, MSB first.
  localparam int TX_W   = 8 + ADDR_W + DATA_W;
  // Bit counter must cover the longest segment: 24 address or 32 data bits.
  localparam int CNT_W  = 5;
  localparam int DSL_W  = $clog2(DESEL_CYC + 1);
  localparam logic [1:0] LEN_MAX  = 2'(MAX_BYTES - 1);
  localparam logic [2:0] NUM_CS_L = 3'(NUM_CS);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DESEL} state_t;

  state_t            state_reg, state_next;
  logic              phase_reg, phase_next;   // 0 = phase A (sclk low), 1 = phase B
  logic [CNT_W-1:0]  cnt_reg, cnt_next;       // bits left in the current segment
  logic [TX_W-1:0]   tx_reg, tx_next;
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              wr_reg, wr_next;
  logic [1:0]        sel_reg, sel_next;
  logic [1:0]        len_reg, len_next;
  logic              bad_reg, bad_next;       // illegal chip select accepted
  logic [DSL_W-1:0]  desel_reg, desel_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              rvalid_reg, rvalid_next;

  logic [DATA_W-1:0] wdata_rev;
  logic [1:0]        len_eff;
  logic              sel_bad;
  logic              active;
  logic [4:0]        rx_idx;

  // Byte 0 goes out first, so place it at the top of the data field.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_wrev
      assign wdata_rev[8*(MAX_BYTES-1-gi) +: 8] = req_wdata_in[8*gi +: 8];
    end
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_n_out[gi] = ~(active && (sel_reg == 2'(gi)));
    end
  endgenerate

  assign len_eff = (req_len_in > LEN_MAX) ? LEN_MAX : req_len_in;
  assign sel_bad = ({1'b0, req_cs_sel_in} >= NUM_CS_L);
  assign active  = (state_reg == CMD) || (state_reg == ADDR) || (state_reg == DATA);
  // Data bits arrive MSB first per byte; byte k of the read lands at rdata[8k+:8].
  assign rx_idx  = {len_reg - cnt_reg[4:3], cnt_reg[2:0]};

  assign req_ready_out   = (state_reg == IDLE);
  assign sclk_out        = active && phase_reg;
  assign mosi_out        = ((state_reg == CMD) || (state_reg == ADDR) ||
                            ((state_reg == DATA) && wr_reg)) ? tx_reg[TX_W-1] : 1'b0;
  assign rdata_out       = rdata_reg;
  assign rdata_valid_out = rvalid_reg;
  assign done_out        = done_reg;
  assign err_out         = err_reg;

  // Next-state and datapath decisions for the transaction sequencer.
  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    cnt_next    = cnt_reg;
    tx_next     = tx_reg;
    rx_next     = rx_reg;
    rdata_next  = rdata_reg;
    wr_next     = wr_reg;
    sel_next    = sel_reg;
    len_next    = len_reg;
    bad_next    = bad_reg;
    desel_next  = desel_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    rvalid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid_in) begin
          wr_next    = req_wr_in;
          sel_next   = req_cs_sel_in;
          len_next   = len_eff;
          rx_next    = '0;
          tx_next    = {(req_wr_in ? 8'h02 : 8'h03), req_addr_in, wdata_rev};
          cnt_next   = 5'd7;
          phase_next = 1'b0;
          if (sel_bad) begin
            // No SPI activity; DESEL spends one cycle reporting the error.
            state_next = DESEL;
            bad_next   = 1'b1;
          end else begin
            state_next = CMD;
          end
        end
      end
      CMD, ADDR, DATA: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          tx_next    = {tx_reg[TX_W-2:0], 1'b0};
          if ((state_reg == DATA) && !wr_reg) begin
            for (int i = 0; i < DATA_W; i++) begin
              if (i == int'(rx_idx)) rx_next[i] = miso_in;
            end
          end
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 5'd1;
          end else begin
            case (state_reg)
              CMD: begin
                state_next = ADDR;
                cnt_next   = 5'(ADDR_W - 1);
              end
              ADDR: begin
                state_next = DATA;
                cnt_next   = {len_reg, 3'b111};
              end
              default: begin
                state_next = DESEL;
                desel_next = DSL_W'(DESEL_CYC - 1);
                done_next  = 1'b1;
                if (!wr_reg) begin
                  rvalid_next = 1'b1;
                  rdata_next  = rx_next;
                end
              end
            endcase
          end
        end
      end
      DESEL: begin
        if (bad_reg) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          bad_next   = 1'b0;
          state_next = IDLE;
        end else if (desel_reg == '0) begin
          state_next = IDLE;
        end else begin
          desel_next = desel_reg - DSL_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_reg  <= IDLE;
      phase_reg  <= 1'b0;
      cnt_reg    <= '0;
      tx_reg     <= '0;
      rx_reg     <= '0;
      rdata_reg  <= '0;
      wr_reg     <= 1'b0;
      sel_reg    <= '0;
      len_reg    <= '0;
      bad_reg    <= 1'b0;
      desel_reg  <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      cnt_reg    <= cnt_next;
      tx_reg     <= tx_next;
      rx_reg     <= rx_next;
      rdata_reg  <= rdata_next;
      wr_reg     <= wr_next;
      sel_reg    <= sel_next;
      len_reg    <= len_next;
      bad_reg    <= bad_next;
      desel_reg  <= desel_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      rvalid_reg <= rvalid_next;
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl_n.sv
// Testbench for spi_mem_ctrl_n: directed and random transactions against a
// transaction-level model plus an SPI slave that serves read bytes on miso.
module tb_spi_mem_ctrl_n;
  localparam int ADDR_W    = 16;
  localparam int MAX_BYTES = 2;
  localparam int NUM_CS    = 2;
  localparam int DESEL_CYC = 2;

  logic                   clk_in = 1'b0;
  logic                   reset_n_in;
  logic                   req_valid_in;
  logic                   req_ready_out;
  logic                   req_wr_in;
  logic [1:0]             req_cs_sel_in;
  logic [ADDR_W-1:0]      req_addr_in;
  logic [1:0]             req_len_in;
  logic [8*MAX_BYTES-1:0] req_wdata_in;
  logic [8*MAX_BYTES-1:0] rdata_out;
  logic                   rdata_valid_out;
  logic                   done_out;
  logic                   err_out;
  logic                   sclk_out;
  logic                   mosi_out;
  logic                   miso_in;
  logic [NUM_CS-1:0]      cs_n_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  spi_mem_ctrl_n #(
    .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .NUM_CS(NUM_CS), .DESEL_CYC(DESEL_CYC)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_wr_in(req_wr_in), .req_cs_sel_in(req_cs_sel_in),
    .req_addr_in(req_addr_in), .req_len_in(req_len_in),
    .req_wdata_in(req_wdata_in), .rdata_out(rdata_out),
    .rdata_valid_out(rdata_valid_out), .done_out(done_out), .err_out(err_out),
    .sclk_out(sclk_out), .mosi_out(mosi_out), .miso_in(miso_in), .cs_n_out(cs_n_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until the DUT shows ready; ok=0 on timeout.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready_out === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk_in); #1;
    end
  endtask

  // One transaction: observations are taken #1 after each clk edge, j=0 being
  // the acceptance edge. rst_at>0 pulls reset so that edge j=rst_at samples it.
  task automatic run_txn(input string name, input logic wr, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [1:0] len,
                         input logic [15:0] wdata, input logic [31:0] sb, input int rst_at);
    bit          legal, ok, bad_cs, bad_idle;
    int          l, nb, n, max_j, done_j, rv_j, err_j, rises, d;
    logic [63:0] exp_bits, cap;
    logic [15:0] exp_rdata, rd_at_done;
    logic [1:0]  exp_cs, cs_j;
    logic        prev_sclk;

    // Transaction-level expectations.
    legal    = (int'(sel) < NUM_CS);
    l        = (int'(len) > MAX_BYTES - 1) ? MAX_BYTES - 1 : int'(len);
    nb       = 8 + ADDR_W + 8 * (l + 1);
    n        = 2 * nb;
    exp_bits = {40'd0, (wr ? 8'h02 : 8'h03), addr};
    exp_rdata = '0;
    for (int i = 0; i <= l; i++) begin
      exp_bits = (exp_bits << 8) | (wr ? 64'(wdata[8*i +: 8]) : 64'd0);
      if (!wr) exp_rdata[8*i +: 8] = sb[8*i +: 8];
    end
    exp_cs = 2'b11;
    if (legal) exp_cs[sel] = 1'b0;

    req_valid_in  = 1'b1;
    req_wr_in     = wr;
    req_cs_sel_in = sel;
    req_addr_in   = addr;
    req_len_in    = len;
    req_wdata_in  = wdata;
    wait_ready(ok);
    check({name, "_ready_timeout"}, 64'(ok), 64'd1);

    done_j = -1; rv_j = -1; err_j = -1; rises = 0; cap = '0; prev_sclk = 1'b0;
    bad_cs = 1'b0; bad_idle = 1'b0; rd_at_done = '0;
    max_j = (legal || rst_at > 0) ? n + 2 : 4;
    for (int j = 0; j <= max_j; j++) begin
      @(posedge clk_in); #1;
      if (j == 0) begin
        // Accepted: scramble the request lines, the transaction must not care.
        req_valid_in  = 1'b0;
        req_wr_in     = ~wr;
        req_cs_sel_in = 2'($urandom_range(0, 3));
        req_addr_in   = 16'($urandom);
        req_len_in    = 2'($urandom_range(0, 3));
        req_wdata_in  = 16'($urandom);
      end
      if (done_out === 1'b1 && done_j < 0) begin
        done_j = j;
        rd_at_done = rdata_out;
      end
      if (rdata_valid_out === 1'b1 && rv_j < 0) rv_j = j;
      if (err_out === 1'b1 && err_j < 0) err_j = j;
      if (rst_at > 0 && j >= rst_at) cs_j = 2'b11;
      else if (legal && j < n) cs_j = exp_cs;
      else cs_j = 2'b11;
      if (cs_n_out !== cs_j) bad_cs = 1'b1;
      if (cs_n_out === 2'b11 && (sclk_out !== 1'b0 || mosi_out !== 1'b0)) bad_idle = 1'b1;
      if (sclk_out === 1'b1 && prev_sclk === 1'b0) begin
        cap = {cap[62:0], mosi_out};
        rises++;
      end
      prev_sclk = sclk_out;
      // Slave: present the next bit while sclk is low; data bits come from sb.
      if (sclk_out === 1'b0) begin
        d = rises - (8 + ADDR_W);
        if (d >= 0 && d < 32) miso_in = sb[8 * (d / 8) + 7 - (d % 8)];
        else miso_in = 1'($urandom_range(0, 1));
      end
      if (rst_at > 0) begin
        if (j == rst_at) begin
          check({name, "_rst_cs"}, 64'(cs_n_out), 64'(2'b11));
          check({name, "_rst_sclk"}, 64'(sclk_out), 64'd0);
        end
        if (j == rst_at - 1) reset_n_in = 1'b0;
        if (j == rst_at + 1) reset_n_in = 1'b1;
      end
    end
    miso_in = 1'b0;

    if (rst_at == 0) begin
      check({name, "_done_at"}, 64'(done_j), 64'(legal ? n : 1));
      check({name, "_err_at"}, 64'(err_j), 64'(legal ? -1 : 1));
      check({name, "_rvalid_at"}, 64'(rv_j), 64'((legal && !wr) ? n : -1));
      if (legal) begin
        check({name, "_mosi_bits"}, 64'(rises), 64'(nb));
        check({name, "_mosi"}, cap, exp_bits);
      end else begin
        check({name, "_no_sclk"}, 64'(rises), 64'd0);
      end
      if (legal && !wr) check({name, "_rdata"}, 64'(rd_at_done), 64'(exp_rdata));
    end else begin
      check({name, "_no_done"}, 64'(done_j), 64'(-1));
      check({name, "_no_rvalid"}, 64'(rv_j), 64'(-1));
      check({name, "_idle_ready"}, 64'(req_ready_out), 64'd1);
      check({name, "_rdata_clr"}, 64'(rdata_out), 64'd0);
    end
    check({name, "_cs_pattern"}, 64'(bad_cs), 64'd0);
    check({name, "_idle_lines"}, 64'(bad_idle), 64'd0);
    $display("TXN %s wr=%0d sel=%0d addr=%h len=%0d done_at=%0d rdata=%h",
             name, wr, sel, addr, len, done_j, rd_at_done);
  endtask

  int   b_d, b_m, b_d2, b_hi, b_acc;
  bit   b_ok, b_hi_done;

  initial begin
    reset_n_in = 1'b0; req_valid_in = 1'b0; req_wr_in = 1'b0; req_cs_sel_in = '0;
    req_addr_in = '0; req_len_in = '0; req_wdata_in = '0; miso_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_cs", 64'(cs_n_out), 64'(2'b11));
    check("reset_sclk", 64'(sclk_out), 64'd0);
    check("reset_mosi", 64'(mosi_out), 64'd0);
    check("reset_pulses", 64'({done_out, err_out, rdata_valid_out}), 64'd0);
    check("reset_rdata", 64'(rdata_out), 64'd0);
    reset_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("reset_ready", 64'(req_ready_out), 64'd1);

    run_txn("rd1",   1'b0, 2'd0, 16'h1234, 2'd0, 16'h0000, 32'h0000_00A5, 0);
    run_txn("wr2",   1'b1, 2'd1, 16'h0F00, 2'd1, 16'hBEEF, 32'h0, 0);
    run_txn("badcs", 1'b0, 2'd3, 16'h5555, 2'd0, 16'h0000, 32'h0, 0);
    run_txn("clamp", 1'b0, 2'd1, 16'hA00C, 2'd3, 16'h0000, 32'h7E3C_5AC3, 0);
    run_txn("rst30", 1'b0, 2'd1, 16'h4321, 2'd1, 16'h0000, 32'h0000_FFFF, 30);

    // Back-to-back reads with valid held high.
    req_valid_in = 1'b1; req_wr_in = 1'b0; req_cs_sel_in = 2'd0;
    req_addr_in = 16'h0100; req_len_in = 2'd0; req_wdata_in = '0; miso_in = 1'b0;
    wait_ready(b_ok);
    check("b2b_ready_timeout", 64'(b_ok), 64'd1);
    b_d = -1; b_m = -1; b_d2 = -1; b_hi = 0; b_hi_done = 1'b0; b_acc = -1;
    for (int j = 0; j < 400; j++) begin
      @(posedge clk_in); #1;
      if (j == b_acc) req_valid_in = 1'b0;
      if (done_out === 1'b1) begin
        if (b_d < 0) b_d = j;
        else if (b_d2 < 0 && j > b_d) b_d2 = j;
      end
      if (b_d >= 0 && !b_hi_done) begin
        if (cs_n_out === 2'b11) b_hi++;
        else b_hi_done = 1'b1;
      end
      if (b_d >= 0 && b_m < 0 && req_ready_out === 1'b1) begin
        b_m = j;
        b_acc = j + 1;
      end
      if (b_d2 >= 0) break;
    end
    check("b2b_accept_gap", 64'(b_acc - b_d), 64'd3);
    check("b2b_cs_high_min", 64'(b_hi >= DESEL_CYC), 64'd1);
    check("b2b_second_done", 64'(b_d2 - b_acc), 64'd64);
    $display("TXN b2b first_done=%0d second_accept=%0d second_done=%0d cs_high=%0d",
             b_d, b_acc, b_d2, b_hi);
    repeat (4) @(posedge clk_in);
    #1;

    for (int t = 0; t < 10; t++) begin
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 1)),
              16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl_n.md
SPI_MEM_CTRL_N -- requirements
Module: spi_mem_ctrl_n

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: SPI address width in bits, legal values 16 or 24.
REQ-002 SHALL have parameter MAX_BYTES, default 2: maximum data bytes per transaction, legal range 1..4.
REQ-003 SHALL have parameter NUM_CS, default 2: number of SPI devices (chip selects), legal range 1..4.
REQ-004 SHALL have parameter DESEL_CYC, default 2: minimum clk cycles CS stays high between transactions, legal range >=1.
REQ-005 SHALL have the port clk_in  in  1  system clock; the block uses this one clock only.
REQ-006 SHALL have the port reset_n_in  in  1  reset, synchronous and active-low.
REQ-007 SHALL have the port req_valid_in  in  1  transaction request.
REQ-008 SHALL have the port req_ready_out  out  1  request accepted when valid&ready.
REQ-009 SHALL have the port req_wr_in  in  1  1=write (cmd 0x02), 0=read (cmd 0x03).
REQ-010 SHALL have the port req_cs_sel_in  in  2  target device index.
REQ-011 SHALL have the port req_addr_in  in  ADDR_W  byte address.
REQ-012 SHALL have the port req_len_in  in  2  byte count minus 1.
REQ-013 SHALL have the port req_wdata_in  in  8*MAX_BYTES  write data.
REQ-014 SHALL have the port rdata_out  out  8*MAX_BYTES  read data.
REQ-015 SHALL have the port rdata_valid_out  out  1  one-cycle pulse when a read completes.
REQ-016 SHALL have the port done_out  out  1  one-cycle pulse at the end of any transaction.
REQ-017 SHALL have the port err_out  out  1  one-cycle pulse, coincident with done_out, for an illegal cs_sel.
REQ-018 SHALL have the port sclk_out  out  1  SPI clock, mode 0.
REQ-019 SHALL have the port mosi_out  out  1  SPI data out.
REQ-020 SHALL have the port miso_in  in  1  SPI data in.
REQ-021 SHALL have the port cs_n_out  out  NUM_CS  active-low chip selects.

Function
REQ-022 SHALL implement an FSM with states IDLE, CMD, ADDR, DATA, DESEL; req_ready_out=1 only in IDLE.
REQ-023 SHALL, on acceptance, latch all req_* inputs; changes to the inputs after acceptance SHALL NOT affect the transaction.
REQ-024 SHALL clamp req_len_in to MAX_BYTES-1 when it exceeds that value.
REQ-025 SHALL, if req_cs_sel_in>=NUM_CS at acceptance, produce no SPI activity, pulse done_out and err_out together 1 cycle after acceptance, and return to IDLE.
REQ-026 SHALL drive cs_n_out[sel] low from the cycle after acceptance until the last bit completes; all other CS bits stay high.
REQ-027 SHALL use 2 clk cycles per bit: phase A (sclk_out=0, mosi_out updated) then phase B (sclk_out=1, miso_in sampled at the end of phase B).
REQ-028 SHALL send MSB first: 8-bit command, then ADDR_W address bits, then 8*(len+1) data bits.
REQ-029 SHALL, for writes, send req_wdata byte 0 (bits 7:0) first, then byte 1, and so on.
REQ-030 SHALL, for reads, store the first received byte in rdata_out[7:0], the next in [15:8], and so on; bytes not transferred SHALL read as 0.
REQ-031 SHALL hold mosi_out=0 during read data phases and whenever CS is inactive.
REQ-032 SHALL assert done_out exactly N = 2*(8+ADDR_W+8*(len+1)) cycles after the acceptance cycle (e.g. ADDR_W=16, len=0: 64).
REQ-033 SHALL, for reads, pulse rdata_valid_out in the same cycle as done_out, with rdata_out already valid and held until the next read completes.
REQ-034 SHALL raise CS in the done_out cycle, then hold all CS high for DESEL_CYC cycles (state DESEL) before returning to IDLE.
REQ-035 SHALL keep sclk_out=0 outside CMD, ADDR and DATA.
REQ-036 SHALL, for back-to-back requests with req_valid_in held high, accept the second request in the first IDLE cycle after DESEL.

Reset
REQ-037 SHALL, while reset_n_in=0 at a clk edge: go to IDLE; cs_n_out all 1; sclk_out=0; mosi_out=0; rdata_out=0; rdata_valid_out, done_out and err_out =0; req_ready_out=1 the cycle after reset is released.
REQ-038 SHALL, on reset during an active transaction, abort the transaction with no done_out pulse and no rdata_valid_out pulse, and deassert CS immediately.

Verification
REQ-039 SHALL cover a 1-byte read, ADDR_W=16, cs=0, addr=0x1234, slave model returns 0xA5 -> MOSI shows 0x03,0x12,0x34; cs_n_out=2'b10; done_out and rdata_valid_out at +64; rdata_out=0x00A5.
REQ-040 SHALL cover a 2-byte write, cs=1, addr=0x0F00, wdata=0xBEEF -> MOSI shows 0x02,0x0F,0x00,0xEF,0xBE; cs_n_out=2'b01; done_out at +80; no rdata_valid_out.
REQ-041 SHALL cover an illegal cs_sel=3 with NUM_CS=2 -> cs_n_out stays 2'b11; sclk_out idle; done_out=err_out=1 at +1.
REQ-042 SHALL cover req_len_in=3 with MAX_BYTES=2 -> clamped to 2 bytes; done_out at +80.
REQ-043 SHALL cover reset_n_in=0 at cycle +30 of a read -> cs_n_out all 1 and sclk_out=0 next cycle; no done_out; IDLE after release.
REQ-044 SHALL cover back-to-back reads with DESEL_CYC=2 -> CS high for 2 cycles between transactions; second acceptance 3 cycles after the first done_out.
